// File: rtl/aes128_pkg.sv
// rtl/aes128_pkg.sv - shared types and constants for the AES-128 word loader
package aes128_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef logic [0:AES_BLOCK_W-1] block_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_MSG,
    ISSUE,
    WAIT
  } loader_state_t;

endpackage

// File: rtl/word_packer.sv
// rtl/word_packer.sv - beat counter plus word-insert register building one 128-bit field, MSB-first
module word_packer
  import aes128_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              first,
  input  logic              clr,
  input  logic [0:WORD_W-1] data,
  output block_t            block,
  output logic              last
);

  localparam int N_WORDS = AES_BLOCK_W / WORD_W;
  localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] idx;

  // A first beat always lands at position 0, whatever the counter held.
  assign idx  = first ? '0 : cnt;
  assign last = (idx == CNT_W'(N_WORDS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      block <= '0;
    end else if (wr) begin
      block[idx*WORD_W +: WORD_W] <= data;
      cnt                         <= last ? '0 : idx + 1'b1;
    end else if (clr) begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/aes128_word_loader.sv
// rtl/aes128_word_loader.sv - assembles key/message words into AES-128 core inputs; AES_LOADER_KEY_REUSE_EN adds key reuse
module aes128_word_loader
  import aes128_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:WORD_W-1] in_data,
  input  logic              in_sop,
  input  logic              in_sel_cypher,
  input  logic              in_reuse_key,
  input  logic              core_done,
  output logic              start,
  output logic              selCypher,
  output block_t            key,
  output block_t            message_in,
  output logic              busy,
  output logic              err
);

  loader_state_t state, next_state;
  logic accept;
  logic key_wr, key_first, key_last;
  logic msg_wr, msg_first, msg_last;
  logic err_set, sel_load;

  assign accept = in_valid & in_ready;

  word_packer #(.WORD_W(WORD_W)) u_key (
    .clk   (clk),
    .reset (reset),
    .wr    (key_wr),
    .first (key_first),
    .clr   (1'b0),
    .data  (in_data),
    .block (key),
    .last  (key_last)
  );

  // A restarted packet must refill the message from beat 0.
  word_packer #(.WORD_W(WORD_W)) u_msg (
    .clk   (clk),
    .reset (reset),
    .wr    (msg_wr),
    .first (msg_first),
    .clr   (key_first),
    .data  (in_data),
    .block (message_in),
    .last  (msg_last)
  );

`ifdef AES_LOADER_KEY_REUSE_EN
  logic key_loaded;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      key_loaded <= 1'b0;
    else if (key_wr) key_loaded <= key_last;
  end
`else
  logic unused_reuse;
  assign unused_reuse = in_reuse_key;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    key_wr     = 1'b0;
    key_first  = 1'b0;
    msg_wr     = 1'b0;
    msg_first  = 1'b0;
    err_set    = 1'b0;
    sel_load   = 1'b0;
    case (state)
      IDLE, LOAD_KEY, LOAD_MSG: begin
        if (accept && in_sop) begin
          err_set  = (state != IDLE);
          sel_load = 1'b1;
`ifdef AES_LOADER_KEY_REUSE_EN
          if (in_reuse_key) begin
            if (key_loaded) begin
              msg_wr     = 1'b1;
              msg_first  = 1'b1;
              next_state = msg_last ? ISSUE : LOAD_MSG;
            end else begin
              err_set    = 1'b1;
              sel_load   = 1'b0;
              next_state = IDLE;
            end
          end else
`endif
          begin
            key_wr     = 1'b1;
            key_first  = 1'b1;
            next_state = key_last ? LOAD_MSG : LOAD_KEY;
          end
        end else if (accept) begin
          if (state == IDLE) begin
            err_set = 1'b1;
          end else if (state == LOAD_KEY) begin
            key_wr = 1'b1;
            if (key_last) next_state = LOAD_MSG;
          end else begin
            msg_wr = 1'b1;
            if (msg_last) next_state = ISSUE;
          end
        end
      end
      ISSUE:   next_state = WAIT;
      WAIT:    if (core_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = reset && (state == IDLE || state == LOAD_KEY || state == LOAD_MSG);
    start    = (state == ISSUE);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      selCypher <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= err_set;
      if (sel_load) selCypher <= in_sel_cypher;
    end
  end

endmodule

// File: tb/tb_aes128_word_loader.sv
// tb/tb_aes128_word_loader.sv - randomized bench for aes128_word_loader against a packet-level model
module tb_aes128_word_loader;

`ifdef AES_LOADER_KEY_REUSE_EN
  localparam bit REUSE_EN = 1'b1;
`else
  localparam bit REUSE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, in_sop, in_sel_cypher, in_reuse_key, core_done;
  logic [0:31]   in_data;
  logic          start, selCypher, busy, err;
  logic [0:127]  key, message_in;

  aes128_word_loader dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_sop        (in_sop),
    .in_sel_cypher (in_sel_cypher),
    .in_reuse_key  (in_reuse_key),
    .core_done     (core_done),
    .start         (start),
    .selCypher     (selCypher),
    .key           (key),
    .message_in    (message_in),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (start) start_cnt++;
    if (err) err_cnt++;
  end

  // Packet-level model: words seen since the last sop, plus the last complete key.
  logic [31:0]  pkt_q[$];
  bit           pkt_open;
  bit           sel_m;
  bit           key_loaded_m;
  logic [127:0] cur_key_m;
  logic [127:0] exp_key, exp_msg;
  bit           exp_sel;
  int           exp_starts;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pkt_q.delete();
    pkt_open     = 1'b0;
    sel_m        = 1'b0;
    key_loaded_m = 1'b0;
    cur_key_m    = '0;
    exp_key      = '0;
    exp_msg      = '0;
    exp_sel      = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d, input bit sop, input bit sel, input bit reuse,
                           input int gap, output bit complete);
    bit err_exp;
    int wait_n;
    complete = 1'b0;
    err_exp  = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid      = 1'b1;
    in_data       = d;
    in_sop        = sop;
    in_sel_cypher = sel;
    in_reuse_key  = reuse;
    core_done     = ($urandom % 8 == 0);
    wait_n = 0;
    while (!in_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    if (wait_n == 50) begin
      check("ready_timeout", in_ready, 1'b1);
      in_valid  = 1'b0;
      core_done = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    in_sop       = 1'b0;
    in_reuse_key = 1'b0;
    core_done    = 1'b0;

    if (sop) begin
      if (reuse && REUSE_EN) begin
        if (key_loaded_m) begin
          err_exp = pkt_open;
          pkt_q.delete();
          for (int i = 0; i < 4; i++) pkt_q.push_back(cur_key_m[127-32*i -: 32]);
          pkt_q.push_back(d);
          pkt_open = 1'b1;
          sel_m    = sel;
        end else begin
          err_exp = 1'b1;
          pkt_q.delete();
          pkt_open = 1'b0;
        end
      end else begin
        err_exp = pkt_open;
        pkt_q.delete();
        pkt_q.push_back(d);
        pkt_open     = 1'b1;
        sel_m        = sel;
        key_loaded_m = 1'b0;
      end
    end else if (!pkt_open) begin
      err_exp = 1'b1;
    end else begin
      pkt_q.push_back(d);
    end
    if (pkt_open && pkt_q.size() == 4) begin
      cur_key_m    = {pkt_q[0], pkt_q[1], pkt_q[2], pkt_q[3]};
      key_loaded_m = 1'b1;
    end
    if (pkt_open && pkt_q.size() == 8) begin
      exp_key  = cur_key_m;
      exp_msg  = {pkt_q[4], pkt_q[5], pkt_q[6], pkt_q[7]};
      exp_sel  = sel_m;
      pkt_open = 1'b0;
      pkt_q.delete();
      complete = 1'b1;
      exp_starts++;
    end

    check("err", err, err_exp);
    check("start", start, complete);
    if (complete) begin
      check("key", key, exp_key);
      check("message_in", message_in, exp_msg);
      check("selCypher", selCypher, exp_sel);
    end
  endtask

  task automatic finish_packet();
    int n;
    n = 1 + $urandom % 4;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("wait_ready", in_ready, 1'b0);
      check("wait_busy", busy, 1'b1);
      check("wait_start", start, 1'b0);
    end
    check("hold_key", key, exp_key);
    check("hold_msg", message_in, exp_msg);
    @(negedge clk);
    core_done = 1'b1;
    @(posedge clk);
    #1;
    core_done = 1'b0;
    check("done_busy", busy, 1'b0);
    check("done_ready", in_ready, 1'b1);
  endtask

  task automatic send_block(input logic [31:0] w[8], input bit sel, input int gap);
    bit c;
    for (int i = 0; i < 8; i++) begin
      push_word(w[i], i == 0, sel, 1'b0, gap, c);
      if (c) finish_packet();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] enc[8];
    logic [31:0] w[8];
    bit c;
    int e0, s0, r, n;

    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_sop = 1'b0;
    in_sel_cypher = 1'b0; in_reuse_key = 1'b0; core_done = 1'b0;
    model_reset();
    exp_starts = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 1'b0);
    check("rst_start", start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_sel", selCypher, 1'b0);
    check("rst_key", key, 128'h0);
    check("rst_msg", message_in, 128'h0);
    @(negedge clk);
    reset = 1'b1;

    // Stray word in IDLE
    push_word(32'hdeadbeef, 1'b0, 1'b0, 1'b0, 0, c);
    check("stray_key", key, 128'h0);
    check("stray_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    check("stray_err_once", err, 1'b0);

    // Encrypt packet
    enc = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
            32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    send_block(enc, 1'b0, 0);
    check("enc_key", key, 128'h000102030405060708090a0b0c0d0e0f);
    check("enc_msg", message_in, 128'h00112233445566778899aabbccddeeff);

`ifdef AES_LOADER_KEY_REUSE_EN
    s0 = start_cnt;
    for (int i = 0; i < 4; i++) begin
      push_word(32'h0, i == 0, 1'b0, i == 0, 0, c);
      if (c) finish_packet();
    end
    check("reuse_key", key, 128'h000102030405060708090a0b0c0d0e0f);
    check("reuse_msg", message_in, 128'h0);
    check("reuse_start", start_cnt - s0, 1);
`endif

    // Back-pressure: valid toggles each cycle
    send_block(enc, 1'b1, 1);
    check("bp_key", key, 128'h000102030405060708090a0b0c0d0e0f);
    check("bp_msg", message_in, 128'h00112233445566778899aabbccddeeff);

    // Mid-packet restart on key word 3
    e0 = err_cnt;
    s0 = start_cnt;
    push_word(32'h11111111, 1'b1, 1'b0, 1'b0, 0, c);
    push_word(32'h22222222, 1'b0, 1'b0, 1'b0, 0, c);
    w = '{32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff, 32'h0, 32'h0, 32'h0, 32'h0};
    send_block(w, 1'b0, 0);
    check("restart_err", err_cnt - e0, 1);
    check("restart_start", start_cnt - s0, 1);
    check("restart_key", key, {128{1'b1}});
    check("restart_msg", message_in, 128'h0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      r = $urandom % 10;
      if (r == 0) begin
        push_word($urandom, 1'b0, 1'b0, 1'b0, $urandom % 3, c);
        if (c) finish_packet();
      end else if (r == 1) begin
        n = $urandom % 6;
        push_word($urandom, 1'b1, $urandom % 2, 1'b0, $urandom % 3, c);
        for (int k = 0; k < n; k++) begin
          push_word($urandom, 1'b0, 1'b0, 1'b0, $urandom % 3, c);
          if (c) finish_packet();
        end
      end else if (r == 2) begin
        for (int k = 0; k < 4; k++) begin
          push_word($urandom, k == 0, $urandom % 2, k == 0, $urandom % 3, c);
          if (c) finish_packet();
        end
      end else begin
        for (int k = 0; k < 8; k++) w[k] = $urandom;
        send_block(w, $urandom % 2, $urandom % 3);
      end
    end

    // Reset asserted between edges while waiting on the core
    w = '{32'h13579bdf, 32'h2468ace0, 32'hfedcba98, 32'h76543210,
          32'h0f1e2d3c, 32'h4b5a6978, 32'h8796a5b4, 32'hc3d2e1f0};
    for (int k = 0; k < 8; k++) push_word(w[k], k == 0, 1'b1, 1'b0, 0, c);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("arst_ready", in_ready, 1'b0);
    check("arst_start", start, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_err", err, 1'b0);
    check("arst_sel", selCypher, 1'b0);
    check("arst_key", key, 128'h0);
    check("arst_msg", message_in, 128'h0);
    model_reset();
    s0 = start_cnt;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready", in_ready, 1'b1);
    check("rel_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rel_no_start", start_cnt - s0, 0);

`ifdef AES_LOADER_KEY_REUSE_EN
    e0 = err_cnt;
    s0 = start_cnt;
    for (int i = 0; i < 4; i++) begin
      push_word(32'h0, i == 0, 1'b0, i == 0, 0, c);
      if (c) finish_packet();
    end
    check("reuse_cold_start", start_cnt - s0, 0);
    check("reuse_cold_err_min", err_cnt - e0 >= 1, 1'b1);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("start_total", start_cnt, exp_starts);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
